block_window_loader: RTL

Upstream feeder for the three-dimensional block selector. Once per frame it walks the beatmap BRAM in time order. It retires blocks that have passed or been sliced, loads newly due blocks into a 12-slot window, computes each slot's depth from the current song time, and publishes the 12-entry arrays atomically. The selector reads these arrays unchanged for the whole frame.

---
 rtl/beatmap_pkg.sv | 46 ++++
 rtl/block_window_loader_if.sv | 15 +
 rtl/free_slot_finder.sv | 23 ++
 rtl/block_window_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/beatmap_pkg.sv
// Beatmap entry layout, window size and loader FSM encoding shared by the loader and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package beatmap_pkg;

   localparam int NUM_SLOTS = 12;
   localparam int ENTRY_W   = 54;
   localparam int SLOT_IDX_W = 4;

   // Entry field offsets and widths inside one beatmap word
   localparam int T_HIT_LSB = 0;
   localparam int T_HIT_W   = 18;
   localparam int X_LSB     = 18;
   localparam int X_W       = 12;
   localparam int Y_LSB     = 30;
   localparam int Y_W       = 12;
   localparam int COLOR_BIT = 42;
   localparam int DIR_LSB   = 43;
   localparam int DIR_W     = 3;
   localparam int ID_LSB    = 46;
   localparam int ID_W      = 8;
   localparam int Z_W       = 14;

   // End-of-map marker in the t_hit field
   localparam logic [T_HIT_W-1:0] T_END = 18'h3FFFF;

   // Packed view of a beatmap word; member order matches the offsets above (MSB first)
   typedef struct packed {
      logic [ID_W-1:0]    id;
      logic [DIR_W-1:0]   direction;
      logic               color;
      logic [Y_W-1:0]     y;
      logic [X_W-1:0]     x;
      logic [T_HIT_W-1:0] t_hit;
   } entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RETIRE,
      ST_FETCH_REQ,
      ST_FETCH_WAIT,
      ST_CHECK,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/block_window_loader_if.sv
// Beatmap BRAM read port between the window loader (master) and the beatmap memory (slave).
// Latency: the memory returns data two cycles after it samples the address.
// Backpressure: none; the master holds the address until it has consumed the data.
// Ports: bram_addr_out (read address), bram_data_in (54-bit beatmap entry).
interface block_window_loader_if
   import beatmap_pkg::*;
#(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0]  bram_addr_out;
   logic [ENTRY_W-1:0] bram_data_in;

   modport master (output bram_addr_out, input bram_data_in);
   modport slave  (input bram_addr_out, output bram_data_in);
endinterface

// File: rtl/free_slot_finder.sv
// Priority encoder: index of the lowest slot whose valid bit is clear.
// Latency: combinational.
// Backpressure: n/a.
// Ports: valid (per-slot occupancy) in; idx (lowest free slot), none_free (window full) out.
module free_slot_finder
   import beatmap_pkg::*;
(
   input  logic [NUM_SLOTS-1:0]  valid,
   output logic [SLOT_IDX_W-1:0] idx,
   output logic                  none_free
);
   always_comb begin
      idx       = '0;
      none_free = 1'b1;
      // Walk downwards so the lowest free index is the one left standing
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            idx       = SLOT_IDX_W'(i);
            none_free = 1'b0;
         end
      end
   end
endmodule

// File: rtl/block_window_loader.sv
// Per-frame window update: retire passed/sliced blocks, load due blocks from the beatmap, publish slot arrays.
// Latency: 3 + 4*(accepted+1) cycles from frame_start_in to new outputs; 3 cycles once the map is done.
// Backpressure: frame_start_in while busy is dropped; restart_in clears everything on the next edge.
// Ports: clk_in/rst_in/restart_in control, frame_start_in + curr_time_in trigger, slice_in per-slot slices,
//        bram (beatmap read port), block_*_out slot arrays, busy_out, map_done_out.
module block_window_loader
   import beatmap_pkg::*;
#(
   parameter int                 ADDR_W    = 10,
   parameter logic [T_HIT_W-1:0] LOOKAHEAD = 18'd2000,
   parameter logic [T_HIT_W-1:0] GRACE     = 18'd100,
   parameter int                 Z_SHIFT   = 2
)(
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             frame_start_in,
   input  logic                             restart_in,
   input  logic [T_HIT_W-1:0]               curr_time_in,
   input  logic [NUM_SLOTS-1:0]             slice_in,
   block_window_loader_if.master            bram,
   output logic [NUM_SLOTS-1:0][X_W-1:0]    block_x_out,
   output logic [NUM_SLOTS-1:0][Y_W-1:0]    block_y_out,
   output logic [NUM_SLOTS-1:0][Z_W-1:0]    block_z_out,
   output logic [NUM_SLOTS-1:0]             block_color_out,
   output logic [NUM_SLOTS-1:0][DIR_W-1:0]  block_direction_out,
   output logic [NUM_SLOTS-1:0][ID_W-1:0]   block_ID_out,
   output logic [NUM_SLOTS-1:0]             block_visible_out,
   output logic                             busy_out,
   output logic                             map_done_out
);
   state_t                  state, state_nxt;
   logic                    wait_cnt;
   logic [ADDR_W-1:0]       ptr;
   logic [T_HIT_W-1:0]      t_now;
   logic                    map_done;
   logic [NUM_SLOTS-1:0]    valid, sliced, retire;
   entry_t                  slot [NUM_SLOTS];

   entry_t                  ent;
   logic                    is_end, too_late, none_free, accept;
   logic [SLOT_IDX_W-1:0]   free_idx;

   // Depth: zero once the hit time is reached, otherwise the scaled distance clamped to the field width
   function automatic logic [Z_W-1:0] depth(input logic [T_HIT_W-1:0] th, input logic [T_HIT_W-1:0] tn);
      logic [T_HIT_W+Z_SHIFT-1:0] d;
      d = '0;
      if (th <= tn) return '0;
      d = {{Z_SHIFT{1'b0}}, T_HIT_W'(th - tn)} << Z_SHIFT;
      if (|d[T_HIT_W+Z_SHIFT-1:Z_W]) return '1;
      return d[Z_W-1:0];
   endfunction

   assign ent      = entry_t'(bram.bram_data_in);
   assign is_end   = (ent.t_hit == T_END);
   // One extra bit so late-song sums cannot wrap
   assign too_late = ({1'b0, ent.t_hit} > ({1'b0, t_now} + {1'b0, LOOKAHEAD}));
   assign accept   = (state == ST_CHECK) && !is_end && !too_late && !none_free;

   assign bram.bram_addr_out = ptr;
   assign busy_out           = (state != ST_IDLE);
   assign map_done_out       = map_done;

   free_slot_finder u_free_slot_finder (
      .valid     (valid),
      .idx       (free_idx),
      .none_free (none_free)
   );

   always_comb begin
      retire = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         retire[i] = sliced[i] | (({1'b0, slot[i].t_hit} + {1'b0, GRACE}) < {1'b0, t_now});
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (frame_start_in) state_nxt = ST_RETIRE;
         ST_RETIRE:     state_nxt = map_done ? ST_COMMIT : ST_FETCH_REQ;
         ST_FETCH_REQ:  state_nxt = ST_FETCH_WAIT;
         ST_FETCH_WAIT: if (wait_cnt) state_nxt = ST_CHECK;
         ST_CHECK:      state_nxt = accept ? ST_FETCH_REQ : ST_COMMIT;
         ST_COMMIT:     state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || restart_in) begin
         state    <= ST_IDLE;
         wait_cnt <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (state == ST_FETCH_WAIT) ? ~wait_cnt : 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || restart_in) begin
         ptr                 <= '0;
         t_now               <= '0;
         map_done            <= 1'b0;
         valid               <= '0;
         sliced              <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
         block_x_out         <= '0;
         block_y_out         <= '0;
         block_z_out         <= '0;
         block_color_out     <= '0;
         block_direction_out <= '0;
         block_ID_out        <= '0;
         block_visible_out   <= '0;
      end else begin
         if (state == ST_IDLE && frame_start_in) t_now <= curr_time_in;

         // Slices are sticky in every state; only a retire clears them
         for (int i = 0; i < NUM_SLOTS; i++) begin
            sliced[i] <= sliced[i] | slice_in[i];
            if (state == ST_RETIRE && retire[i]) begin
               valid[i]  <= 1'b0;
               sliced[i] <= 1'b0;
            end
         end

         if (state == ST_CHECK && is_end) map_done <= 1'b1;

         // Rejected entries leave ptr alone so they are fetched again next frame
         if (accept) begin
            slot[free_idx]   <= ent;
            valid[free_idx]  <= 1'b1;
            sliced[free_idx] <= 1'b0;
            ptr              <= ptr + 1'b1;
         end

         if (state == ST_COMMIT) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               block_x_out[i]         <= slot[i].x;
               block_y_out[i]         <= slot[i].y;
               block_z_out[i]         <= depth(slot[i].t_hit, t_now);
               block_color_out[i]     <= slot[i].color;
               block_direction_out[i] <= slot[i].direction;
               block_ID_out[i]        <= slot[i].id;
               block_visible_out[i]   <= valid[i] & ~sliced[i];
            end
         end
      end
   end
endmodule
